// File: rtl/mem_lsu_pkg.sv
// Shared CPU definitions for the load/store unit: opcodes, funct3 codes, FSM states, lane helpers.
package mem_lsu_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  localparam logic [2:0] ITYPE_STORE = 3'd4;
  localparam logic [2:0] ITYPE_LOAD  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } lsu_state_e;

  function automatic logic f3_known(input logic [2:0] f3, input logic is_load);
    if (is_load) return f3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
    return f3 inside {F3_SB, F3_SH, F3_SW};
  endfunction

  // Store and load codes share values for B/H/W, so one check serves both.
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
    case (f3)
      F3_LW:         return lo != 2'b00;
      F3_LH, F3_LHU: return lo[0];
      default:       return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] idx);
    case (f3)
      F3_SB:   return 4'b0001 << idx;
      F3_SH:   return idx[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      F3_SB:   return {4{d[7:0]}};
      F3_SH:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// Data-bus port of the load/store unit: one outstanding req/ack transaction at a time.
interface mem_lsu_if;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic [3:0]  bus_strb_o;
  logic        bus_ack_i;
  logic [31:0] bus_rdata_i;

  modport master (
    output bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_strb_o,
    input  bus_ack_i, bus_rdata_i
  );

  modport slave (
    input  bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_strb_o,
    output bus_ack_i, bus_rdata_i
  );
endinterface

// File: rtl/mem_lsu_load_align.sv
// Combinational load-data extraction: selects the byte/half lane and sign- or zero-extends it.
module lsu_load_align
  import mem_lsu_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_idx,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_rdata[{i_idx, 3'b000} +: 8];
  assign w_half = i_rdata[{i_idx[1], 4'b0000} +: 16];

  always_comb begin
    o_data = i_rdata;
    case (i_funct3)
      F3_LB:   o_data = {{24{w_byte[7]}}, w_byte};
      F3_LBU:  o_data = {24'd0, w_byte};
      F3_LH:   o_data = {{16{w_half[15]}}, w_half};
      F3_LHU:  o_data = {16'd0, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Load/store unit: runs one req/ack bus access with timeout, returns a registered writeback record.
// Latency 1 cycle (pass-through/misaligned) or >=2 (bus access); stall held from accept through ack.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lsu_valid_i,
  input  logic [31:0] lsu_pc_i,
  input  logic [31:0] lsu_inst_i,
  input  logic        lsu_wr_mem_en_i,
  input  logic        lsu_load_i,
  input  logic [31:0] lsu_mem_addr_i,
  input  logic [1:0]  lsu_wr_index_i,
  input  logic [1:0]  lsu_rd_index_i,
  input  logic [31:0] lsu_wr_data_i,
  input  logic [31:0] lsu_reg_wdata_i,
  input  logic        lsu_wr_reg_en_i,
  input  logic [4:0]  lsu_wr_reg_addr_i,
  mem_lsu_if.master   bus,
  output logic        lsu_stall_o,
  output logic        wb_valid_o,
  output logic [31:0] wb_pc_o,
  output logic [31:0] wb_inst_o,
  output logic [31:0] wb_wdata_o,
  output logic        wb_wr_en_o,
  output logic [4:0]  wb_wr_addr_o,
  output logic        lsu_misalign_o,
  output logic        lsu_bus_err_o
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  lsu_state_e    r_state, w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic          r_we, r_is_load, r_ld_wr_en;
  logic [31:0]   r_addr, r_wdata;
  logic [3:0]    r_strb;
  logic [1:0]    r_idx;
  logic [2:0]    r_f3;
  logic          r_wb_valid, r_wb_wr_en, r_misal, r_bus_err;
  logic [31:0]   r_wb_pc, r_wb_inst, r_wb_wdata;
  logic [4:0]    r_wb_wr_addr;

  logic [2:0]    w_f3;
  logic          w_is_mem, w_misal, w_start, w_ack, w_timeout;
  logic [31:0]   w_load_data;

  assign w_f3      = lsu_inst_i[14:12];
  assign w_is_mem  = lsu_valid_i & (lsu_load_i | lsu_wr_mem_en_i) & f3_known(w_f3, lsu_load_i);
  assign w_misal   = w_is_mem & misaligned(w_f3, lsu_mem_addr_i[1:0]);
  assign w_start   = (r_state != ST_REQ) & w_is_mem & ~w_misal;
  assign w_ack     = (r_state == ST_REQ) & bus.bus_ack_i;
  assign w_timeout = (r_state == ST_REQ) & ~bus.bus_ack_i & (r_cnt == CNT_LAST);

  lsu_load_align u_align (
    .i_rdata  (bus.bus_rdata_i),
    .i_idx    (r_idx),
    .i_funct3 (r_f3),
    .o_data   (w_load_data)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // IDLE and DONE behave identically: DONE only exists to present the record while accepting the next access.
  always_comb begin
    w_state_nxt = r_state;
    lsu_stall_o = 1'b0;
    case (r_state)
      ST_REQ: begin
        lsu_stall_o = 1'b1;
        if (w_ack | w_timeout) w_state_nxt = ST_DONE;
      end
      default: begin
        lsu_stall_o = w_start;
        w_state_nxt = w_start ? ST_REQ : ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0; r_we <= 1'b0; r_is_load <= 1'b0; r_ld_wr_en <= 1'b0;
      r_addr <= '0; r_wdata <= '0; r_strb <= '0; r_idx <= '0; r_f3 <= '0;
      r_wb_valid <= 1'b0; r_wb_wr_en <= 1'b0; r_misal <= 1'b0; r_bus_err <= 1'b0;
      r_wb_pc <= '0; r_wb_inst <= '0; r_wb_wdata <= '0; r_wb_wr_addr <= '0;
    end else begin
      r_wb_valid <= 1'b0;
      r_misal    <= 1'b0;
      r_bus_err  <= 1'b0;
      if (r_state == ST_REQ) begin
        r_cnt <= r_cnt + 1'b1;
        if (w_ack | w_timeout) begin
          r_wb_valid <= 1'b1;
          r_bus_err  <= w_timeout;
          r_wb_wr_en <= w_ack & r_ld_wr_en;
          if (w_ack & r_is_load) r_wb_wdata <= w_load_data;
        end
      end else if (lsu_valid_i) begin
        // Pass-through fields go straight into the record; for bus accesses they wait there until completion.
        r_wb_pc      <= lsu_pc_i;
        r_wb_inst    <= lsu_inst_i;
        r_wb_wdata   <= lsu_reg_wdata_i;
        r_wb_wr_addr <= lsu_wr_reg_addr_i;
        if (w_start) begin
          r_cnt      <= '0;
          r_wb_wr_en <= 1'b0;
          r_we       <= ~lsu_load_i;
          r_is_load  <= lsu_load_i;
          r_ld_wr_en <= lsu_load_i & lsu_wr_reg_en_i & (lsu_wr_reg_addr_i != 5'd0);
          r_addr     <= {lsu_mem_addr_i[31:2], 2'b00};
          r_wdata    <= store_wdata(w_f3, lsu_wr_data_i);
          r_strb     <= lsu_load_i ? 4'b0000 : store_strb(w_f3, lsu_wr_index_i);
          r_idx      <= lsu_rd_index_i;
          r_f3       <= w_f3;
        end else begin
          r_wb_valid <= 1'b1;
          r_misal    <= w_misal;
          r_wb_wr_en <= lsu_wr_reg_en_i & ~w_misal;
        end
      end
    end
  end

  assign bus.bus_req_o   = (r_state == ST_REQ);
  assign bus.bus_we_o    = r_we;
  assign bus.bus_addr_o  = r_addr;
  assign bus.bus_wdata_o = r_wdata;
  assign bus.bus_strb_o  = r_strb;

  assign wb_valid_o     = r_wb_valid;
  assign wb_pc_o        = r_wb_pc;
  assign wb_inst_o      = r_wb_inst;
  assign wb_wdata_o     = r_wb_wdata;
  assign wb_wr_en_o     = r_wb_wr_en;
  assign wb_wr_addr_o   = r_wb_wr_addr;
  assign lsu_misalign_o = r_misal;
  assign lsu_bus_err_o  = r_bus_err;

endmodule

// File: tb/tb_mem_lsu.sv
// Scoreboard bench for mem_lsu: expected writeback records are queued at issue and popped when wb_valid_o fires.
module tb_mem_lsu;
  import mem_lsu_pkg::*;

  localparam int TO = 4;

  logic        clk;
  logic        rst;
  logic        lsu_valid_i, lsu_wr_mem_en_i, lsu_load_i, lsu_wr_reg_en_i;
  logic [31:0] lsu_pc_i, lsu_inst_i, lsu_mem_addr_i, lsu_wr_data_i, lsu_reg_wdata_i;
  logic [1:0]  lsu_wr_index_i, lsu_rd_index_i;
  logic [4:0]  lsu_wr_reg_addr_i;
  logic        lsu_stall_o, wb_valid_o, wb_wr_en_o, lsu_misalign_o, lsu_bus_err_o;
  logic [31:0] wb_pc_o, wb_inst_o, wb_wdata_o;
  logic [4:0]  wb_wr_addr_o;

  mem_lsu_if bus_if ();

  mem_lsu #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .lsu_valid_i(lsu_valid_i), .lsu_pc_i(lsu_pc_i), .lsu_inst_i(lsu_inst_i),
    .lsu_wr_mem_en_i(lsu_wr_mem_en_i), .lsu_load_i(lsu_load_i), .lsu_mem_addr_i(lsu_mem_addr_i),
    .lsu_wr_index_i(lsu_wr_index_i), .lsu_rd_index_i(lsu_rd_index_i), .lsu_wr_data_i(lsu_wr_data_i),
    .lsu_reg_wdata_i(lsu_reg_wdata_i), .lsu_wr_reg_en_i(lsu_wr_reg_en_i), .lsu_wr_reg_addr_i(lsu_wr_reg_addr_i),
    .bus(bus_if),
    .lsu_stall_o(lsu_stall_o), .wb_valid_o(wb_valid_o), .wb_pc_o(wb_pc_o), .wb_inst_o(wb_inst_o),
    .wb_wdata_o(wb_wdata_o), .wb_wr_en_o(wb_wr_en_o), .wb_wr_addr_o(wb_wr_addr_o),
    .lsu_misalign_o(lsu_misalign_o), .lsu_bus_err_o(lsu_bus_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [2:0]  f3;
    logic        st;
    logic        ld;
    logic [31:0] addr;
    logic [1:0]  idx;
    logic [31:0] data;
    logic [31:0] rwdata;
    logic        wen;
    logic [4:0]  waddr;
  } req_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] wdata;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic        misal;
    logic        err;
  } wb_t;

  wb_t sb_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  // Observations of the most recent run_access call.
  logic        o_stall0, o_wb_stall, o_we;
  int          o_reqs, o_stalls, o_wbk;
  logic [31:0] o_addr, o_wdata;
  logic [3:0]  o_strb;

  function automatic logic [31:0] inst_of(input req_t r);
    logic [6:0] op;
    op = r.st ? OP_STORE : (r.ld ? OP_LOAD : 7'b0110011);
    return {17'd0, r.f3, r.waddr, op};
  endfunction

  function automatic wb_t exp_rec(input req_t r, input logic [31:0] wd, input logic we_x,
                                  input logic mis_x, input logic err_x);
    wb_t e;
    e.pc = r.pc; e.inst = inst_of(r); e.wdata = wd; e.wr_en = we_x;
    e.wr_addr = r.waddr; e.misal = mis_x; e.err = err_x;
    return e;
  endfunction

  function automatic wb_t wb_now();
    wb_t w;
    w.pc = wb_pc_o; w.inst = wb_inst_o; w.wdata = wb_wdata_o; w.wr_en = wb_wr_en_o;
    w.wr_addr = wb_wr_addr_o; w.misal = lsu_misalign_o; w.err = lsu_bus_err_o;
    return w;
  endfunction

  task automatic apply(input req_t r);
    lsu_valid_i = 1'b1; lsu_pc_i = r.pc; lsu_inst_i = inst_of(r);
    lsu_wr_mem_en_i = r.st; lsu_load_i = r.ld; lsu_mem_addr_i = r.addr;
    lsu_wr_index_i = r.idx; lsu_rd_index_i = r.idx; lsu_wr_data_i = r.data;
    lsu_reg_wdata_i = r.rwdata; lsu_wr_reg_en_i = r.wen; lsu_wr_reg_addr_i = r.waddr;
  endtask

  // Presents r in the current cycle, acks in cycle N+ack_at (0 = never) and returns at the
  // negedge of the writeback cycle (o_wbk = its offset from N, 0 if none within the budget).
  task automatic run_access(input req_t r, input int ack_at, input logic [31:0] rdata);
    logic first;
    apply(r);
    #1 o_stall0 = lsu_stall_o;
    @(posedge clk); #1 lsu_valid_i = 1'b0;
    o_reqs = 0; o_stalls = 0; o_wbk = 0; o_wb_stall = 1'b0; first = 1'b1;
    o_addr = '0; o_wdata = '0; o_strb = '0; o_we = 1'b0;
    for (int k = 1; k <= 40 && o_wbk == 0; k++) begin
      if (k == ack_at) begin bus_if.bus_ack_i = 1'b1; bus_if.bus_rdata_i = rdata; end
      @(negedge clk);
      if (wb_valid_o) begin
        o_wbk = k; o_wb_stall = lsu_stall_o;
      end else begin
        if (bus_if.bus_req_o) begin
          o_reqs++;
          if (first) begin
            o_addr = bus_if.bus_addr_o; o_wdata = bus_if.bus_wdata_o;
            o_strb = bus_if.bus_strb_o; o_we = bus_if.bus_we_o; first = 1'b0;
          end
        end
        if (lsu_stall_o) o_stalls++;
        @(posedge clk); #1 bus_if.bus_ack_i = 1'b0;
      end
    end
    bus_if.bus_ack_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; lsu_valid_i = 1'b0; lsu_wr_mem_en_i = 1'b0; lsu_load_i = 1'b0; lsu_wr_reg_en_i = 1'b0;
    lsu_pc_i = '0; lsu_inst_i = '0; lsu_mem_addr_i = '0; lsu_wr_data_i = '0; lsu_reg_wdata_i = '0;
    lsu_wr_index_i = '0; lsu_rd_index_i = '0; lsu_wr_reg_addr_i = '0;
    bus_if.bus_ack_i = 1'b0; bus_if.bus_rdata_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({bus_if.bus_req_o, bus_if.bus_we_o, bus_if.bus_addr_o, bus_if.bus_wdata_o, bus_if.bus_strb_o} !== 70'd0) begin
      n_bad++; $display("FAIL reset_bus: got req=%b we=%b addr=%h wdata=%h strb=%b want all 0",
        bus_if.bus_req_o, bus_if.bus_we_o, bus_if.bus_addr_o, bus_if.bus_wdata_o, bus_if.bus_strb_o);
    end
    n_cmp++;
    if ({lsu_stall_o, wb_valid_o, wb_now()} !== '0) begin
      n_bad++; $display("FAIL reset_wb: got stall=%b valid=%b rec=%h want all 0", lsu_stall_o, wb_valid_o, wb_now());
    end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus_if.bus_req_o, lsu_stall_o, wb_valid_o} !== 3'b000) begin
      n_bad++; $display("FAIL reset_idle: got req=%b stall=%b valid=%b want 000", bus_if.bus_req_o, lsu_stall_o, wb_valid_o);
    end
  endtask

  task automatic test_store_word();
    req_t r;
    wb_t  exp_w, got;
    r = '{pc:32'h100, f3:F3_SW, st:1'b1, ld:1'b0, addr:32'h1000_0004, idx:2'd0,
          data:32'hDEAD_BEEF, rwdata:32'h0, wen:1'b0, waddr:5'd0};
    sb_q.push_back(exp_rec(r, 32'h0, 1'b0, 1'b0, 1'b0));
    @(posedge clk); #1 run_access(r, 3, 32'h0);
    n_cmp++; if (o_stall0 !== 1'b1) begin n_bad++; $display("FAIL sw_stall_N: got %b want 1", o_stall0); end
    n_cmp++; if (o_reqs != 3) begin n_bad++; $display("FAIL sw_req_cycles: got %0d want 3", o_reqs); end
    n_cmp++; if (o_stalls != 3) begin n_bad++; $display("FAIL sw_stall_cycles: got %0d want 3", o_stalls); end
    n_cmp++; if (o_wbk != 4) begin n_bad++; $display("FAIL sw_latency: got %0d want 4", o_wbk); end
    n_cmp++;
    if ({o_we, o_addr, o_wdata, o_strb} !== {1'b1, 32'h1000_0004, 32'hDEAD_BEEF, 4'b1111}) begin
      n_bad++; $display("FAIL sw_bus: got we=%b addr=%h wdata=%h strb=%b want 1 10000004 deadbeef 1111", o_we, o_addr, o_wdata, o_strb);
    end
    n_cmp++; if (o_wb_stall !== 1'b0) begin n_bad++; $display("FAIL sw_stall_wb: got %b want 0", o_wb_stall); end
    exp_w = sb_q.pop_front(); got = wb_now(); n_cmp++;
    if (o_wbk == 0 || got !== exp_w) begin n_bad++; $display("FAIL sw_rec: got %h want %h", got, exp_w); end
  endtask

  task automatic test_store_lanes();
    logic [2:0]  f3s[4]  = '{F3_SB, F3_SB, F3_SH, F3_SH};
    logic [31:0] adr[4]  = '{32'h2000_0003, 32'h2000_0001, 32'h2000_0006, 32'h2000_0004};
    logic [31:0] dat[4]  = '{32'h0000_00A5, 32'h1111_223C, 32'h0000_1234, 32'hFFFF_BEEF};
    logic [31:0] ewd[4]  = '{32'hA5A5_A5A5, 32'h3C3C_3C3C, 32'h1234_1234, 32'hBEEF_BEEF};
    logic [3:0]  estb[4] = '{4'b1000, 4'b0010, 4'b1100, 4'b0011};
    logic [31:0] eadr[4] = '{32'h2000_0000, 32'h2000_0000, 32'h2000_0004, 32'h2000_0004};
    req_t r;
    wb_t  exp_w, got;
    for (int i = 0; i < 4; i++) begin
      r = '{pc:32'h200 + 32'(4*i), f3:f3s[i], st:1'b1, ld:1'b0, addr:adr[i], idx:adr[i][1:0],
            data:dat[i], rwdata:32'h55, wen:1'b1, waddr:5'd9};
      sb_q.push_back(exp_rec(r, 32'h55, 1'b0, 1'b0, 1'b0));
      @(posedge clk); #1 run_access(r, 1, 32'h0);
      n_cmp++;
      if ({o_addr, o_wdata, o_strb, o_we} !== {eadr[i], ewd[i], estb[i], 1'b1}) begin
        n_bad++; $display("FAIL store_lane[%0d]: got addr=%h wdata=%h strb=%b we=%b want %h %h %b 1",
          i, o_addr, o_wdata, o_strb, o_we, eadr[i], ewd[i], estb[i]);
      end
      exp_w = sb_q.pop_front(); got = wb_now(); n_cmp++;
      if (o_wbk != 2 || got !== exp_w) begin
        n_bad++; $display("FAIL store_rec[%0d]: got %h at +%0d want %h at +2", i, got, o_wbk, exp_w);
      end
    end
  endtask

  task automatic test_loads();
    logic [2:0]  f3s[7] = '{F3_LB, F3_LBU, F3_LH, F3_LHU, F3_LW, F3_LB, F3_LH};
    logic [1:0]  ids[7] = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd0, 2'd1, 2'd0};
    logic [31:0] rdt[7] = '{32'h0080_0000, 32'h0080_0000, 32'h8001_0000, 32'h8001_0000,
                            32'h1234_5678, 32'h0000_7F00, 32'h0000_FFFE};
    logic [31:0] ers[7] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'h0000_8001,
                            32'h1234_5678, 32'h0000_007F, 32'hFFFF_FFFE};
    req_t r;
    wb_t  exp_w, got;
    for (int i = 0; i < 7; i++) begin
      r = '{pc:32'h300 + 32'(4*i), f3:f3s[i], st:1'b0, ld:1'b1, addr:32'h3000_0000 | 32'(ids[i]),
            idx:ids[i], data:32'hFFFF_FFFF, rwdata:32'h0, wen:1'b1, waddr:5'd5};
      sb_q.push_back(exp_rec(r, ers[i], 1'b1, 1'b0, 1'b0));
      @(posedge clk); #1 run_access(r, 2, rdt[i]);
      n_cmp++;
      if ({o_we, o_strb, o_addr, o_reqs} !== {1'b0, 4'b0000, 32'h3000_0000, 32'd2}) begin
        n_bad++; $display("FAIL load_bus[%0d]: got we=%b strb=%b addr=%h reqs=%0d want 0 0000 30000000 2",
          i, o_we, o_strb, o_addr, o_reqs);
      end
      exp_w = sb_q.pop_front(); got = wb_now(); n_cmp++;
      if (o_wbk != 3 || got !== exp_w) begin
        n_bad++; $display("FAIL load_rec[%0d]: got %h at +%0d want %h at +3", i, got, o_wbk, exp_w);
      end
    end
    r = '{pc:32'h3F0, f3:F3_LW, st:1'b0, ld:1'b1, addr:32'h3000_0010, idx:2'd0,
          data:32'h0, rwdata:32'h0, wen:1'b1, waddr:5'd0};
    sb_q.push_back(exp_rec(r, 32'h1122_3344, 1'b0, 1'b0, 1'b0));
    @(posedge clk); #1 run_access(r, 1, 32'h1122_3344);
    n_cmp++; if (o_reqs != 1) begin n_bad++; $display("FAIL load_x0_bus: got reqs=%0d want 1", o_reqs); end
    exp_w = sb_q.pop_front(); got = wb_now(); n_cmp++;
    if (o_wbk != 2 || got !== exp_w) begin n_bad++; $display("FAIL load_x0_rec: got %h want %h", got, exp_w); end
  endtask

  task automatic test_misalign_passthrough();
    req_t rs[4];
    logic mis[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    wb_t  exp_w, got;
    rs[0] = '{pc:32'h400, f3:F3_LW, st:1'b0, ld:1'b1, addr:32'h4000_0002, idx:2'd2,
              data:32'h0, rwdata:32'h77, wen:1'b1, waddr:5'd3};
    rs[1] = '{pc:32'h404, f3:F3_SH, st:1'b1, ld:1'b0, addr:32'h4000_0001, idx:2'd1,
              data:32'h1234, rwdata:32'h78, wen:1'b0, waddr:5'd0};
    rs[2] = '{pc:32'h408, f3:3'd0, st:1'b0, ld:1'b0, addr:32'h0, idx:2'd0,
              data:32'h0, rwdata:32'hCAFE_F00D, wen:1'b1, waddr:5'd7};
    rs[3] = '{pc:32'h40C, f3:3'd3, st:1'b0, ld:1'b1, addr:32'h4000_0008, idx:2'd0,
              data:32'h0, rwdata:32'h1357, wen:1'b0, waddr:5'd8};
    for (int i = 0; i < 4; i++) begin
      sb_q.push_back(exp_rec(rs[i], rs[i].rwdata, mis[i] ? 1'b0 : rs[i].wen, mis[i], 1'b0));
      @(posedge clk); #1 run_access(rs[i], 0, 32'h0);
      n_cmp++;
      if ({o_stall0, o_reqs} !== {1'b0, 32'd0}) begin
        n_bad++; $display("FAIL nobus[%0d]: got stall=%b reqs=%0d want 0 0", i, o_stall0, o_reqs);
      end
      exp_w = sb_q.pop_front(); got = wb_now(); n_cmp++;
      if (o_wbk != 1 || got !== exp_w) begin
        n_bad++; $display("FAIL nobus_rec[%0d]: got %h at +%0d want %h at +1", i, got, o_wbk, exp_w);
      end
    end
  endtask

  task automatic test_timeout();
    req_t r;
    wb_t  exp_w, got;
    r = '{pc:32'h500, f3:F3_SW, st:1'b1, ld:1'b0, addr:32'h5000_0000, idx:2'd0,
          data:32'h0BAD_0BAD, rwdata:32'h9, wen:1'b0, waddr:5'd0};
    sb_q.push_back(exp_rec(r, 32'h9, 1'b0, 1'b0, 1'b1));
    @(posedge clk); #1 run_access(r, 0, 32'h0);
    n_cmp++; if (o_reqs != TO) begin n_bad++; $display("FAIL to_req_cycles: got %0d want %0d", o_reqs, TO); end
    exp_w = sb_q.pop_front(); got = wb_now(); n_cmp++;
    if (o_wbk != TO + 1 || got !== exp_w) begin
      n_bad++; $display("FAIL to_rec: got %h at +%0d want %h at +%0d", got, o_wbk, exp_w, TO + 1);
    end
    @(posedge clk); #1 bus_if.bus_ack_i = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({lsu_bus_err_o, wb_valid_o, lsu_stall_o, bus_if.bus_req_o} !== 4'b0000) begin
      n_bad++; $display("FAIL to_idle: got err=%b valid=%b stall=%b req=%b want 0000",
        lsu_bus_err_o, wb_valid_o, lsu_stall_o, bus_if.bus_req_o);
    end
    @(posedge clk); #1 bus_if.bus_ack_i = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({wb_valid_o, bus_if.bus_req_o} !== 2'b00) begin
      n_bad++; $display("FAIL idle_ack_ignored: got valid=%b req=%b want 00", wb_valid_o, bus_if.bus_req_o);
    end
  endtask

  task automatic test_back_to_back();
    req_t ra, rb;
    wb_t  exp_w, got;
    ra = '{pc:32'h600, f3:F3_LBU, st:1'b0, ld:1'b1, addr:32'h6000_0003, idx:2'd3,
           data:32'h0, rwdata:32'h0, wen:1'b1, waddr:5'd12};
    rb = '{pc:32'h604, f3:F3_SW, st:1'b1, ld:1'b0, addr:32'h6000_0008, idx:2'd0,
           data:32'h0F0F_0F0F, rwdata:32'h44, wen:1'b0, waddr:5'd0};
    sb_q.push_back(exp_rec(ra, 32'h0000_00C3, 1'b1, 1'b0, 1'b0));
    sb_q.push_back(exp_rec(rb, 32'h44, 1'b0, 1'b0, 1'b0));
    @(posedge clk); #1 run_access(ra, 1, 32'hC300_0000);
    exp_w = sb_q.pop_front(); got = wb_now(); n_cmp++;
    if (o_wbk != 2 || got !== exp_w) begin n_bad++; $display("FAIL b2b_first: got %h want %h", got, exp_w); end
    run_access(rb, 1, 32'h0);
    n_cmp++;
    if ({o_stall0, o_reqs, o_addr} !== {1'b1, 32'd1, 32'h6000_0008}) begin
      n_bad++; $display("FAIL b2b_accept: got stall=%b reqs=%0d addr=%h want 1 1 60000008", o_stall0, o_reqs, o_addr);
    end
    exp_w = sb_q.pop_front(); got = wb_now(); n_cmp++;
    if (o_wbk != 2 || got !== exp_w) begin n_bad++; $display("FAIL b2b_second: got %h want %h", got, exp_w); end
  endtask

  task automatic test_reset_mid();
    req_t r;
    wb_t  exp_w, got;
    r = '{pc:32'h700, f3:F3_LW, st:1'b0, ld:1'b1, addr:32'h7000_0000, idx:2'd0,
          data:32'h0, rwdata:32'h0, wen:1'b1, waddr:5'd4};
    @(posedge clk); #1 apply(r);
    @(posedge clk); #1 lsu_valid_i = 1'b0; rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus_if.bus_req_o !== 1'b1) begin n_bad++; $display("FAIL rstmid_inflight: got req=%b want 1", bus_if.bus_req_o); end
    @(posedge clk); #1 rst = 1'b0; bus_if.bus_ack_i = 1'b1; bus_if.bus_rdata_i = 32'hBADB_AD00;
    @(negedge clk);
    n_cmp++;
    if ({bus_if.bus_req_o, wb_valid_o, lsu_stall_o} !== 3'b000) begin
      n_bad++; $display("FAIL rstmid_after: got req=%b valid=%b stall=%b want 000", bus_if.bus_req_o, wb_valid_o, lsu_stall_o);
    end
    @(posedge clk); #1 bus_if.bus_ack_i = 1'b0;
    @(negedge clk);
    n_cmp++; if (wb_valid_o !== 1'b0) begin n_bad++; $display("FAIL rstmid_no_wb: got valid=%b want 0", wb_valid_o); end
    r.pc = 32'h708; r.f3 = F3_LH; r.addr = 32'h7000_0002; r.idx = 2'd2;
    sb_q.push_back(exp_rec(r, 32'h0000_7FFF, 1'b1, 1'b0, 1'b0));
    @(posedge clk); #1 run_access(r, 2, 32'h7FFF_0000);
    exp_w = sb_q.pop_front(); got = wb_now(); n_cmp++;
    if (o_wbk != 3 || got !== exp_w) begin n_bad++; $display("FAIL rstmid_later: got %h at +%0d want %h at +3", got, o_wbk, exp_w); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_store_word();
    test_store_lanes();
    test_loads();
    test_misalign_passthrough();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_lsu.md
# mem_lsu

Load/store unit sitting between the ALU stage and the data bus. It consumes the ALU's memory request: store enable, effective address, byte index and store data, plus the load flag and pass-through writeback fields. It runs the bus transaction with a req/ack handshake and a timeout. It returns a registered writeback record to the write-back stage, aligning and sign-extending load data as required, and stalls the pipeline while a transaction is outstanding.

## Interface
Parameters:
- TIMEOUT, 16, maximum cycles `bus_req_o` stays high without `bus_ack_i` before the access is aborted (≥2).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high (fixed by design).
- lsu_valid_i  in  1  ALU stage presents an instruction this cycle.
- lsu_pc_i / lsu_inst_i  in  32/32  PC and instruction; funct3 = inst[14:12] selects width/sign.
- lsu_wr_mem_en_i  in  1  store request.
- lsu_load_i  in  1  load request (mutually exclusive with store).
- lsu_mem_addr_i  in  32  effective address.
- lsu_wr_index_i / lsu_rd_index_i  in  2/2  byte offset for store / load.
- lsu_wr_data_i  in  32  store data (rs2).
- lsu_reg_wdata_i, lsu_wr_reg_en_i, lsu_wr_reg_addr_i  in  32/1/5  ALU writeback fields.
- bus_req_o  out  1  request, held until ack or timeout.
- bus_we_o  out  1  1 = write.
- bus_addr_o  out  32  word-aligned address ({addr[31:2],2'b00}).
- bus_wdata_o  out  32  lane-replicated store data.
- bus_strb_o  out  4  byte strobes (0 on reads).
- bus_ack_i  in  1  one-cycle completion pulse; `bus_rdata_i` valid the same cycle.
- bus_rdata_i  in  32  read word.
- lsu_stall_o  out  1  combinational; hold upstream stages.
- wb_valid_o, wb_pc_o, wb_inst_o, wb_wdata_o, wb_wr_en_o, wb_wr_addr_o  out  1/32/32/32/1/5  registered writeback record.
- lsu_misalign_o / lsu_bus_err_o  out  1/1  one-cycle fault pulses, aligned with `wb_valid_o`.

## Operation
- FSM states: IDLE, REQ, DONE.
- IDLE, valid non-memory instruction: register the pass-through fields; `wb_valid_o`=1 next cycle. No stall.
- IDLE, valid load/store:
  - Misaligned access (W: addr[1:0]≠0; H/HU: addr[0]≠0): no bus cycle. Next cycle `wb_valid_o`=1, `lsu_misalign_o`=1, `wb_wr_en_o`=0.
  - Otherwise: latch address, strobes, data, funct3 and writeback fields; go to REQ.
- REQ: `bus_req_o`=1 with stable address, strobes and data.
  - On ack: capture the result and go to DONE.
  - If the timeout counter reaches TIMEOUT-1 without ack: drop the request, go to DONE with `lsu_bus_err_o`=1 and `wb_wr_en_o`=0.
- DONE: present the record for one cycle (`wb_valid_o`=1), then IDLE. A new instruction is accepted in DONE, so back-to-back accesses are allowed.
- Store lanes:
  - SB: wdata = {4{d[7:0]}}, strb = 4'b0001<<idx.
  - SH: wdata = {2{d[15:0]}}, strb = idx[1] ? 4'b1100 : 4'b0011.
  - SW: strb = 4'b1111.
  - Stores force `wb_wr_en_o`=0.
- Load extract: byte rdata[8*idx+:8], half rdata[16*idx[1]+:16]. LB/LH sign-extend, LBU/LHU zero-extend, LW full word.
- Loads to x0 perform the bus read, but `wb_wr_en_o`=0.
- Unknown funct3 on load/store: treated as a pass-through (NOP), no bus cycle.

## Timing
- Reset values: all outputs 0; FSM=IDLE; timeout counter=0.
- Accept in cycle N: `lsu_stall_o`=1 in cycle N (combinational on request in IDLE/DONE) and stays high through the ack cycle.
- `bus_req_o` rises at N+1.
- Ack in cycle M ≥ N+1: `bus_req_o` low at M+1; `wb_valid_o`/result at M+1; stall low in M+1.
- Minimum load/store latency is 2 cycles; pass-through and misaligned latency is 1 cycle.
- Timeout: with no ack, `bus_req_o` is high for exactly TIMEOUT cycles and `lsu_bus_err_o` pulses on the following cycle.
- An ack arriving while in IDLE/DONE is ignored.
- Reset mid-transaction: `bus_req_o` is 0 after the reset edge, and no `wb_valid_o` is produced for the aborted access.

## Structure
- Shared CPU package holds: the opcode constants (LOAD 0000011, STORE 0100011), funct3 codes LB/LH/LW/LBU/LHU/SB/SH/SW, the FSM state encoding, and the instruction-type codes (Store=4, Load=5) used by the ALU stage.
- One sub-module: `lsu_load_align`. It is combinational and takes rdata, idx and funct3, and returns the extended word.

## Test plan
- SW addr 0x1000_0004, data 0xDEADBEEF, ack at N+3 -> bus_addr 0x1000_0004, strb 1111, req high N+1..N+3, stall high N..N+3, wb_wr_en=0.
- SB addr 0x…0003, data 0x000000A5 -> wdata 0xA5A5A5A5, strb 1000.
- LB idx 2, rdata 0x0080_0000 -> wb_wdata 0xFFFFFF80. LBU gives 0x00000080. LH idx 2, rdata 0x8001_0000 -> 0xFFFF8001.
- LW addr 0x…0002 -> no bus_req, misalign pulse at N+1, wb_wr_en=0.
- TIMEOUT=4, never ack -> req high exactly 4 cycles, bus_err pulse next cycle, FSM returns to IDLE.
- Load in flight, rst asserted at M-1 -> bus_req 0 and wb_valid 0 after the edge; a later load completes normally.
